multicycle_decode: RTL and testbench

Multicycle successor to the single-cycle ARM decoder. A Moore state machine sequences fetch, decode, memory, ALU and branch steps over several cycles. It also adds a start/done handshake to a multi-cycle floating-point unit (FADD/FMUL), guarded by a timeout. It sits between the instruction register / condition logic and the shared-memory multicycle datapath.

---
 rtl/multicycle_decode_pkg.sv | 39 +++
 rtl/multicycle_decode_alu_decode.sv | 40 ++++
 rtl/multicycle_decode.sv | 117 +++++++++++
 tb/tb_multicycle_decode.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_decode_pkg.sv
// multicycle_pkg: state encodings, ALU codes and datapath select constants
// shared by the multicycle decoder and its bench.
package multicycle_pkg;
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_FPEXEC = 4'd10;
    localparam logic [3:0] S_FPWAIT = 4'd11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_ADC  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_FADD = 3'b100;
    localparam logic [2:0] ALU_FMUL = 3'b101;

    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_ADD  = 4'b0100;
    localparam logic [3:0] CMD_CMP  = 4'b1010;
    localparam logic [3:0] CMD_FADD = 4'b1100;
    localparam logic [3:0] CMD_FMUL = 4'b1101;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] SRCA_RD1   = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCB_RD2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;
endpackage

// File: rtl/multicycle_decode_alu_decode.sv
// alu_decode: maps the data-processing cmd field to ALU operation, flag write
// enables and a no-write-back indication for compares and unknown codes.
module alu_decode
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [3:0]           i_cmd,
    input  logic                 i_s,
    input  logic                 i_cond_ex,
    input  logic                 i_alu_en,
    output logic [ALUCTRL_W-1:0] o_alu_control,
    output logic [1:0]           o_flag_w,
    output logic                 o_nowrite
);
    logic [2:0] w_ctrl;
    logic       w_known;
    logic       w_arith;

    always_comb begin
        w_ctrl  = ALU_ADD;
        w_known = 1'b1;
        case (i_cmd)
            CMD_ADD:  w_ctrl = ALU_ADD;
            CMD_SUB:  w_ctrl = ALU_SUB;
            CMD_AND:  w_ctrl = ALU_AND;
            CMD_FADD: w_ctrl = ALU_FADD;
            CMD_FMUL: w_ctrl = ALU_FMUL;
            CMD_CMP:  w_ctrl = ALU_SUB;
            default:  w_known = 1'b0;
        endcase
    end

    // CMP is a subtraction, so it updates C/V just like ADD and SUB
    assign w_arith       = i_cmd == CMD_ADD || i_cmd == CMD_SUB || i_cmd == CMD_CMP;
    assign o_alu_control = i_alu_en ? ALUCTRL_W'(w_ctrl) : ALUCTRL_W'(ALU_ADD);
    assign o_flag_w[1]   = i_alu_en & i_s & i_cond_ex;
    assign o_flag_w[0]   = o_flag_w[1] & w_arith;
    assign o_nowrite     = !w_known || i_cmd == CMD_CMP;
endmodule

// File: rtl/multicycle_decode.sv
// multicycle_decode: Moore control FSM for the multicycle ARM datapath, with a
// start/done handshake to a multi-cycle FP unit guarded by a timeout.
module multicycle_decode
    import multicycle_pkg::*;
#(
    parameter int         ALUCTRL_W  = 3,
    parameter int         FP_TIMEOUT = 16,
    parameter logic [3:0] PC_REG     = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           i_op,
    input  logic [5:0]           i_funct,
    input  logic [3:0]           i_rd,
    input  logic                 i_cond_ex,
    input  logic                 i_fp_done,
    output logic                 o_pc_write,
    output logic                 o_reg_write,
    output logic                 o_mem_write,
    output logic                 o_ir_write,
    output logic                 o_adr_src,
    output logic [1:0]           o_result_src,
    output logic [1:0]           o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [1:0]           o_imm_src,
    output logic [1:0]           o_reg_src,
    output logic [ALUCTRL_W-1:0] o_alu_control,
    output logic [1:0]           o_flag_w,
    output logic                 o_fp_start,
    output logic                 o_fp_error,
    output logic                 o_illegal
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_cnt;
    logic       r_fp_error;
    logic       w_fp_op;
    logic       w_timeout;
    logic       w_exec;
    logic       w_alu_en;
    logic       w_nowrite;
    logic       w_wb;
    logic       w_rd_pc;
    logic [1:0] w_flag_w;

    assign w_fp_op   = i_funct[4:1] == CMD_FADD || i_funct[4:1] == CMD_FMUL;
    assign w_timeout = r_cnt == 8'(FP_TIMEOUT - 1);
    assign w_exec    = r_state == S_EXECR || r_state == S_EXECI;
    assign w_alu_en  = w_exec || r_state == S_FPEXEC || r_state == S_FPWAIT || r_state == S_ALUWB;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = i_op == 2'b01 ? S_MEMADR :
                               i_op == 2'b10 ? S_BRANCH :
                               i_op == 2'b11 ? S_FETCH  :
                               w_fp_op       ? (i_funct[5] ? S_FETCH : S_FPEXEC) :
                               i_funct[5]    ? S_EXECI  : S_EXECR;
            S_MEMADR: w_next = i_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_next = S_ALUWB;
            S_FPEXEC: w_next = i_cond_ex ? S_FPWAIT : S_FETCH;
            S_FPWAIT: w_next = i_fp_done ? S_ALUWB : w_timeout ? S_FETCH : S_FPWAIT;
            default:  w_next = S_FETCH;
        endcase
    end

    // done wins over timeout, so the error flag only sets on a silent final cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_fp_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FPEXEC)
                r_cnt <= '0;
            else if (r_state == S_FPWAIT && !i_fp_done)
                r_cnt <= r_cnt + 8'd1;
            if (r_state == S_FPWAIT && !i_fp_done && w_timeout)
                r_fp_error <= 1'b1;
        end
    end

    alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
        .i_cmd         (i_funct[4:1]),
        .i_s           (i_funct[0]),
        .i_cond_ex     (i_cond_ex),
        .i_alu_en      (w_alu_en),
        .o_alu_control (o_alu_control),
        .o_flag_w      (w_flag_w),
        .o_nowrite     (w_nowrite)
    );

    assign w_wb    = r_state == S_MEMWB || (r_state == S_ALUWB && !w_nowrite);
    assign w_rd_pc = i_rd == PC_REG;

    assign o_pc_write   = r_state == S_FETCH || (r_state == S_BRANCH && i_cond_ex) ||
                          (w_wb && w_rd_pc && i_cond_ex);
    assign o_reg_write  = w_wb && !w_rd_pc && i_cond_ex;
    assign o_mem_write  = r_state == S_MEMWR && i_cond_ex;
    assign o_ir_write   = r_state == S_FETCH;
    assign o_adr_src    = r_state == S_MEMRD || r_state == S_MEMWR;
    assign o_result_src = (r_state == S_FETCH || r_state == S_DECODE || r_state == S_BRANCH) ? RES_ALU :
                          r_state == S_MEMWB ? RES_DATA : RES_ALUOUT;
    assign o_alu_src_a  = (r_state == S_FETCH || r_state == S_DECODE) ? SRCA_PC : SRCA_RD1;
    assign o_alu_src_b  = (r_state == S_FETCH || r_state == S_DECODE) ? SRCB_FOUR :
                          (r_state == S_MEMADR || r_state == S_EXECI || r_state == S_BRANCH) ? SRCB_IMM : SRCB_RD2;
    assign o_imm_src    = r_state == S_MEMADR ? 2'b01 : r_state == S_BRANCH ? 2'b10 : 2'b00;
    assign o_reg_src    = {r_state == S_MEMWR, r_state == S_BRANCH};
    assign o_flag_w     = w_exec ? w_flag_w : 2'b00;
    assign o_fp_start   = r_state == S_FPEXEC && i_cond_ex;
    assign o_fp_error   = r_fp_error;
    assign o_illegal    = r_state == S_DECODE && (i_op == 2'b11 || (i_op == 2'b00 && w_fp_op && i_funct[5]));
endmodule

// File: tb/tb_multicycle_decode.sv
// tb_multicycle_decode: builds the expected per-cycle output trace of each
// instruction from the control rules and checks the decoder every cycle.
module tb_multicycle_decode;
    localparam int FP_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic       cond = 1'b0;
    logic       done = 1'b0;

    logic       o_pc_write, o_reg_write, o_mem_write, o_ir_write, o_adr_src;
    logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src, o_reg_src, o_flag_w;
    logic [2:0] o_alu_control;
    logic       o_fp_start, o_fp_error, o_illegal;

    multicycle_decode #(.ALUCTRL_W(3), .FP_TIMEOUT(FP_TIMEOUT), .PC_REG(4'hF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_op          (op),
        .i_funct       (funct),
        .i_rd          (rd),
        .i_cond_ex     (cond),
        .i_fp_done     (done),
        .o_pc_write    (o_pc_write),
        .o_reg_write   (o_reg_write),
        .o_mem_write   (o_mem_write),
        .o_ir_write    (o_ir_write),
        .o_adr_src     (o_adr_src),
        .o_result_src  (o_result_src),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_imm_src     (o_imm_src),
        .o_reg_src     (o_reg_src),
        .o_alu_control (o_alu_control),
        .o_flag_w      (o_flag_w),
        .o_fp_start    (o_fp_start),
        .o_fp_error    (o_fp_error),
        .o_illegal     (o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, rw, mw, irw, adr;
        logic [1:0] res, sa, sb, imm, rs;
        logic [2:0] alu;
        logic [1:0] fw;
        logic       fps, ill, err;
    } out_t;

    out_t  act_o, exp_o;
    logic  exp_valid = 1'b0;
    string exp_name = "";
    int    n_tests = 0;
    int    n_fail = 0;
    logic  err_model = 1'b0;
    bit    tmo;
    out_t  tq[$];
    logic  dq[$];
    string nq[$];

    assign act_o = {o_pc_write, o_reg_write, o_mem_write, o_ir_write, o_adr_src,
                    o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src, o_reg_src,
                    o_alu_control, o_flag_w, o_fp_start, o_illegal, o_fp_error};

    always @(negedge clk) begin
        if (exp_valid) begin
            n_tests++;
            if (act_o !== exp_o) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", exp_name, act_o, exp_o);
            end
        end
    end

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic out_t base();
        out_t r = '0;
        r.err = err_model;
        return r;
    endfunction

    function automatic logic [2:0] aluc(input logic [3:0] c);
        logic [2:0] tbl [16];
        for (int i = 0; i < 16; i++) tbl[i] = 3'd0;
        tbl[4] = 3'd0; tbl[2] = 3'd2; tbl[0] = 3'd3; tbl[12] = 3'd4; tbl[13] = 3'd5; tbl[10] = 3'd2;
        return tbl[c];
    endfunction

    function automatic out_t wb(input out_t r, input logic [3:0] d, input logic c);
        if (d == 4'hF) r.pcw = c;
        else r.rw = c;
        return r;
    endfunction

    function automatic out_t aluwb(input logic [3:0] c, input logic [3:0] d, input logic cc);
        out_t r = base();
        r.alu = aluc(c);
        if (c inside {4'd0, 4'd2, 4'd4, 4'd12, 4'd13}) r = wb(r, d, cc);
        return r;
    endfunction

    task automatic push(input out_t r, input string n, input logic d);
        tq.push_back(r);
        nq.push_back(n);
        dq.push_back(d);
    endtask

    // dl: FPWAIT cycle (1-based) on which fp_done pulses; 0 = never, <0 = every cycle
    task automatic gen(input logic [1:0] a_op, input logic [5:0] a_fn, input logic [3:0] a_rd,
                       input logic a_c, input int dl, output bit to);
        logic [3:0] c = a_fn[4:1];
        bit   fpop = a_op == 2'd0 && (c == 4'd12 || c == 4'd13);
        logic dall = dl < 0;
        out_t r;
        tq.delete(); nq.delete(); dq.delete();
        to = 0;
        r = base(); r.irw = 1; r.pcw = 1; r.sa = 1; r.sb = 2; r.res = 2;
        push(r, "FETCH", dall);
        r = base(); r.sa = 1; r.sb = 2; r.res = 2;
        r.ill = a_op == 2'd3 || (fpop && a_fn[5]);
        push(r, "DECODE", dall);
        if (r.ill) return;
        if (a_op == 2'd1) begin
            r = base(); r.sb = 1; r.imm = 1; push(r, "MEMADR", dall);
            if (a_fn[0]) begin
                r = base(); r.adr = 1; push(r, "MEMRD", dall);
                r = base(); r.res = 1; r = wb(r, a_rd, a_c); push(r, "MEMWB", dall);
            end else begin
                r = base(); r.adr = 1; r.rs = 2; r.mw = a_c; push(r, "MEMWR", dall);
            end
        end else if (a_op == 2'd2) begin
            r = base(); r.sb = 1; r.imm = 2; r.rs = 1; r.res = 2; r.pcw = a_c;
            push(r, "BRANCH", dall);
        end else if (fpop) begin
            r = base(); r.alu = aluc(c); r.fps = a_c; push(r, "FPEXEC", dall);
            if (!a_c) return;
            for (int k = 0; k < FP_TIMEOUT; k++) begin
                logic d = dall || (k + 1 == dl);
                r = base(); r.alu = aluc(c); push(r, "FPWAIT", d);
                if (d) begin
                    push(aluwb(c, a_rd, a_c), "ALUWB", dall);
                    return;
                end
            end
            to = 1;
        end else begin
            r = base(); r.sb = a_fn[5] ? 2'd1 : 2'd0; r.alu = aluc(c);
            r.fw[1] = a_fn[0] & a_c;
            r.fw[0] = r.fw[1] & (c == 4'd4 || c == 4'd2 || c == 4'd10);
            push(r, a_fn[5] ? "EXECI" : "EXECR", dall);
            push(aluwb(c, a_rd, a_c), "ALUWB", dall);
        end
    endtask

    task automatic run(input logic [1:0] a_op, input logic [5:0] a_fn, input logic [3:0] a_rd,
                       input logic a_c, input int dl, input int nmax = 1000);
        bit to;
        gen(a_op, a_fn, a_rd, a_c, dl, to);
        op = a_op; funct = a_fn; rd = a_rd; cond = a_c;
        for (int i = 0; i < tq.size() && i < nmax; i++) begin
            done = dq[i]; exp_o = tq[i]; exp_name = nq[i]; exp_valid = 1'b1;
            @(posedge clk); #1;
        end
        exp_valid = 1'b0;
        done = 1'b0;
        if (to && nmax >= tq.size()) err_model = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_irwrite", o_ir_write, 1);
        check("rst_pcwrite", o_pc_write, 1);
        check("rst_srcab", {o_alu_src_a, o_alu_src_b}, 4'b0110);
        check("rst_result", o_result_src, 2);
        check("rst_zero", {o_reg_write, o_mem_write, o_fp_start, o_illegal, o_fp_error,
                           o_flag_w, o_alu_control, o_adr_src, o_imm_src, o_reg_src}, 0);
        rst_n = 1'b1;

        gen(2'd1, 6'b011001, 4'd3, 1'b1, 0, tmo);
        check("model_ldr_len", tq.size(), 5);
        check("model_ldr_rw", {tq[0].rw, tq[1].rw, tq[2].rw, tq[3].rw, tq[4].rw}, 5'b00001);
        gen(2'd0, 6'b001001, 4'd2, 1'b1, 0, tmo);
        check("model_adds_ex", {tq[2].alu, tq[2].fw}, 5'b00011);
        gen(2'd0, 6'b011010, 4'd2, 1'b1, 3, tmo);
        check("model_fmul_len", tq.size(), 7);
        check("model_fmul_wb", {tq[5].alu, tq[6].rw, tq[2].fps}, 5'b10111);

        // reset while sitting in MEMWR with the store enabled
        run(2'd1, 6'b011000, 4'd4, 1'b1, 0, 3);
        check("memwr_pre_reset", o_mem_write, 1);
        rst_n = 1'b0;
        #1;
        check("memwr_in_reset", o_mem_write, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        err_model = 1'b0;
        check("post_reset_fetch", {o_ir_write, o_pc_write, o_mem_write}, 3'b110);

        run(2'd1, 6'b011001, 4'd3, 1'b1, 0);
        run(2'd1, 6'b011001, 4'd15, 1'b1, 0);
        run(2'd1, 6'b011000, 4'd4, 1'b1, 0);
        run(2'd1, 6'b011000, 4'd4, 1'b0, 0);
        run(2'd0, 6'b001001, 4'd2, 1'b1, 0);
        run(2'd0, 6'b001001, 4'd15, 1'b1, 0);
        run(2'd0, 6'b101000, 4'd5, 1'b0, 0);
        run(2'd0, 6'b100101, 4'd6, 1'b1, 0);
        run(2'd0, 6'b000001, 4'd7, 1'b1, 0);
        run(2'd0, 6'b010101, 4'd0, 1'b1, 0);
        run(2'd0, 6'b000011, 4'd1, 1'b1, -1);
        run(2'd2, 6'b100000, 4'd0, 1'b1, 0);
        run(2'd2, 6'b100000, 4'd0, 1'b0, -1);
        run(2'd0, 6'b011010, 4'd2, 1'b1, 3);
        run(2'd0, 6'b011010, 4'd15, 1'b1, 1);
        run(2'd0, 6'b011010, 4'd2, 1'b0, 0);
        run(2'd0, 6'b011000, 4'd8, 1'b1, -1);
        run(2'd3, 6'b000000, 4'd1, 1'b1, 0);
        run(2'd0, 6'b111000, 4'd1, 1'b1, 0);
        run(2'd0, 6'b011000, 4'd9, 1'b1, 0);
        check("fp_error_sticky", o_fp_error, 1);
        run(2'd0, 6'b001000, 4'd2, 1'b1, 0);
        run(2'd0, 6'b011000, 4'd9, 1'b1, 16);

        rst_n = 1'b0;
        #1;
        check("fp_error_reset", o_fp_error, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
